// File: rtl/sim_mem_dp.sv
// Dual-port word memory with byte-lane writes and read-before-write semantics for simulation.
// Latency: RD_LATENCY clocks from request to x_valid/x_dout; every request returns one pulse.
// Backpressure: none; a request is accepted on every clock its x_req is high.
module sim_mem_dp #(
  parameter int SIZE       = 100,
  parameter int WIDTH      = 36,
  parameter int NBYTES     = 3,
  parameter int RD_LATENCY = 1,
  localparam int AW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [0:NBYTES-1] a_wea,
  input  logic [AW-1:0]     a_addr,
  input  logic [0:WIDTH-1]  a_din,
  output logic [0:WIDTH-1]  a_dout,
  output logic              a_valid,
  output logic              a_err,
  input  logic              b_req,
  input  logic [0:NBYTES-1] b_wea,
  input  logic [AW-1:0]     b_addr,
  input  logic [0:WIDTH-1]  b_din,
  output logic [0:WIDTH-1]  b_dout,
  output logic              b_valid,
  output logic              b_err
);

  localparam int          LW     = WIDTH / NBYTES;
  localparam logic [AW:0] SIZE_W = SIZE[AW:0];

  if (WIDTH % NBYTES != 0) begin : g_bad_lanes
    $error("sim_mem_dp: WIDTH must be a multiple of NBYTES");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("sim_mem_dp: RD_LATENCY must be 1..4");
  end

  typedef struct packed {
    logic             vld;
    logic             err;
    logic [0:WIDTH-1] dat;
  } stage_t;

  // Storage; benches reach in hierarchically to preload and inspect it.
  logic [0:WIDTH-1] mem [0:SIZE-1];

  // Ports folded into arrays (index 0 = A, 1 = B) so both share one datapath description.
  logic              p_req   [2];
  logic [0:NBYTES-1] p_wea   [2];
  logic [AW-1:0]     p_addr  [2];
  logic [0:WIDTH-1]  p_din   [2];
  logic              p_ok    [2];
  logic [0:WIDTH-1]  rd_word [2];
  stage_t            pipe    [2][RD_LATENCY];

  assign p_req[0]  = a_req;
  assign p_req[1]  = b_req;
  assign p_wea[0]  = a_wea;
  assign p_wea[1]  = b_wea;
  assign p_addr[0] = a_addr;
  assign p_addr[1] = b_addr;
  assign p_din[0]  = a_din;
  assign p_din[1]  = b_din;

  // Range check and pre-write array read; out-of-range addresses read as zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      p_ok[p]    = ({1'b0, p_addr[p]} < SIZE_W);
      rd_word[p] = '0;
      if (p_ok[p]) begin
        rd_word[p] = mem[p_addr[p]];
      end
    end
  end

  // Lane writes; A is issued after B so A's nonblocking update wins a shared lane.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int l = 0; l < NBYTES; l++) begin
        if (p_req[1] && p_ok[1] && p_wea[1][l]) begin
          mem[p_addr[1]][l*LW +: LW] <= p_din[1][l*LW +: LW];
        end
        if (p_req[0] && p_ok[0] && p_wea[0][l]) begin
          mem[p_addr[0]][l*LW +: LW] <= p_din[0][l*LW +: LW];
        end
      end
    end
  end

  // Read pipelines; data only advances with a valid so the last stage holds between pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < RD_LATENCY; k++) begin
          pipe[p][k] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pipe[p][0].vld <= p_req[p];
        pipe[p][0].err <= p_req[p] && !p_ok[p];
        if (p_req[p]) begin
          pipe[p][0].dat <= rd_word[p];
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
          pipe[p][k].vld <= pipe[p][k-1].vld;
          pipe[p][k].err <= pipe[p][k-1].err;
          if (pipe[p][k-1].vld) begin
            pipe[p][k].dat <= pipe[p][k-1].dat;
          end
        end
      end
    end
  end

  assign a_dout  = pipe[0][RD_LATENCY-1].dat;
  assign a_valid = pipe[0][RD_LATENCY-1].vld;
  assign a_err   = pipe[0][RD_LATENCY-1].err;
  assign b_dout  = pipe[1][RD_LATENCY-1].dat;
  assign b_valid = pipe[1][RD_LATENCY-1].vld;
  assign b_err   = pipe[1][RD_LATENCY-1].err;

endmodule

// File: tb/tb_sim_mem_dp.sv
// Bench for sim_mem_dp: one instance at read latency 1 and one at latency 3 share all inputs.
// A reference array plus a per-cycle response schedule predicts every dout/valid/err.
// Directed cases cover lane writes, port collisions, range errors and reset flushing; then random traffic.
module tb_sim_mem_dp;
  localparam int SIZE  = 100;
  localparam int WIDTH = 36;
  localparam int NB    = 3;
  localparam int LW    = WIDTH / NB;
  localparam int AW    = 7;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             a_req = 1'b0, b_req = 1'b0;
  logic [0:NB-1]    a_wea = '0, b_wea = '0;
  logic [AW-1:0]    a_addr = '0, b_addr = '0;
  logic [0:WIDTH-1] a_din = '0, b_din = '0;
  logic [0:WIDTH-1] a_dout1, b_dout1, a_dout3, b_dout3;
  logic             a_valid1, b_valid1, a_valid3, b_valid3;
  logic             a_err1, b_err1, a_err3, b_err3;

  sim_mem_dp #(.SIZE(SIZE), .WIDTH(WIDTH), .NBYTES(NB), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wea(a_wea), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1), .a_err(a_err1),
    .b_req(b_req), .b_wea(b_wea), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout1), .b_valid(b_valid1), .b_err(b_err1)
  );

  sim_mem_dp #(.SIZE(SIZE), .WIDTH(WIDTH), .NBYTES(NB), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wea(a_wea), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout3), .a_valid(a_valid3), .a_err(a_err3),
    .b_req(b_req), .b_wea(b_wea), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout3), .b_valid(b_valid3), .b_err(b_err3)
  );

  always #5 clk = ~clk;

  // Observed outputs indexed k: 0 = dut1 A, 1 = dut1 B, 2 = dut3 A, 3 = dut3 B.
  logic [0:WIDTH-1] obs_dout [4];
  logic             obs_vld  [4];
  logic             obs_err  [4];
  assign obs_dout[0] = a_dout1;  assign obs_vld[0] = a_valid1;  assign obs_err[0] = a_err1;
  assign obs_dout[1] = b_dout1;  assign obs_vld[1] = b_valid1;  assign obs_err[1] = b_err1;
  assign obs_dout[2] = a_dout3;  assign obs_vld[2] = a_valid3;  assign obs_err[2] = a_err3;
  assign obs_dout[3] = b_dout3;  assign obs_vld[3] = b_valid3;  assign obs_err[3] = b_err3;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word array plus responses scheduled by the cycle they must appear.
  logic [0:WIDTH-1] ref_mem  [0:SIZE-1];
  logic             sch_vld  [4][8];
  logic             sch_err  [4][8];
  logic [0:WIDTH-1] sch_dat  [4][8];
  logic [0:WIDTH-1] last_dout [4];
  int               cyc = 0;
  int               pulses3 = 0;

  function automatic int lat(input int k);
    return (k < 2) ? 1 : 3;
  endfunction

  // One clock: drive inputs, advance the model at the edge, then compare all outputs.
  task automatic cycle(input logic rst_n,
                       input logic ar, input logic [0:NB-1] aw, input logic [AW-1:0] aa, input logic [0:WIDTH-1] ad,
                       input logic br, input logic [0:NB-1] bw, input logic [AW-1:0] ba, input logic [0:WIDTH-1] bd);
    int slot;
    logic rq;
    logic [AW-1:0] ra;
    logic [0:WIDTH-1] exp_d;
    logic exp_v, exp_e;
    reset_n = rst_n;
    a_req = ar; a_wea = aw; a_addr = aa; a_din = ad;
    b_req = br; b_wea = bw; b_addr = ba; b_din = bd;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++)
        for (int s = 0; s < 8; s++) sch_vld[k][s] = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        rq = (k % 2 == 0) ? ar : br;
        ra = (k % 2 == 0) ? aa : ba;
        if (rq) begin
          slot = (cyc + lat(k) - 1) % 8;
          sch_vld[k][slot] = 1'b1;
          sch_err[k][slot] = (int'(ra) >= SIZE);
          sch_dat[k][slot] = (int'(ra) >= SIZE) ? '0 : ref_mem[ra];
        end
      end
      for (int l = 0; l < NB; l++) begin
        if (br && int'(ba) < SIZE && bw[l]) ref_mem[ba][l*LW +: LW] = bd[l*LW +: LW];
      end
      for (int l = 0; l < NB; l++) begin
        if (ar && int'(aa) < SIZE && aw[l]) ref_mem[aa][l*LW +: LW] = ad[l*LW +: LW];
      end
    end
    #1;
    slot = cyc % 8;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        exp_v = 1'b0; exp_e = 1'b0; exp_d = '0; last_dout[k] = '0;
      end else if (sch_vld[k][slot]) begin
        exp_v = 1'b1; exp_e = sch_err[k][slot]; exp_d = sch_dat[k][slot]; last_dout[k] = exp_d;
      end else begin
        exp_v = 1'b0; exp_e = 1'b0; exp_d = last_dout[k];
      end
      sch_vld[k][slot] = 1'b0;
      chk($sformatf("valid[%0d]@%0d", k, cyc), 64'(obs_vld[k]), 64'(exp_v));
      chk($sformatf("err[%0d]@%0d", k, cyc), 64'(obs_err[k]), 64'(exp_e));
      chk($sformatf("dout[%0d]@%0d", k, cyc), 64'(obs_dout[k]), 64'(exp_d));
      if (k == 2 && obs_vld[2]) pulses3++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0, 3'($urandom_range(7, 0)), '0, 36'($urandom()),
                  1'b0, 3'($urandom_range(7, 0)), '0, 36'($urandom()));
  endtask

  task automatic rd_a(input logic [AW-1:0] addr);
    cycle(1'b1, 1'b1, 3'b000, addr, '0, 1'b0, 3'b000, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(9, 0);
    if (r < 7) return 7'($urandom_range(7, 0));
    return 7'($urandom_range(101, 96));
  endfunction

  logic [63:0]      rnd;
  logic [0:WIDTH-1] w, pre5, pre6, old9;

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      rnd = {$urandom(), $urandom()};
      w = rnd[35:0];
      ref_mem[i] = w;
      dut1.mem[i] = w;
      dut3.mem[i] = w;
    end
    ref_mem[7'h13] = 36'h123456789; dut1.mem[7'h13] = 36'h123456789; dut3.mem[7'h13] = 36'h123456789;
    ref_mem[7'h17] = 36'h987654321; dut1.mem[7'h17] = 36'h987654321; dut3.mem[7'h17] = 36'h987654321;
    for (int k = 0; k < 4; k++) begin
      last_dout[k] = '0;
      for (int s = 0; s < 8; s++) sch_vld[k][s] = 1'b0;
    end
    pre5 = ref_mem[5];
    pre6 = ref_mem[6];
    old9 = ref_mem[9];

    // Reset, including full-lane write requests that must be discarded.
    cycle(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    cycle(1'b0, 1'b1, 3'b111, 7'h05, 36'hfffffffff, 1'b1, 3'b111, 7'h06, 36'h000000000);
    cycle(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    chk("rst_wr_a", 64'(dut1.mem[5]), 64'(pre5));
    chk("rst_wr_b", 64'(dut3.mem[6]), 64'(pre6));

    // Preloaded reads, A then B, first request right after reset release.
    rd_a(7'h13);
    chk("pre_a_dout", 64'(a_dout1), 64'(36'h123456789));
    chk("pre_a_vld", 64'(a_valid1), 64'd1);
    cycle(1'b1, 1'b0, 3'b000, '0, '0, 1'b1, 3'b000, 7'h17, '0);
    chk("pre_b_dout", 64'(b_dout1), 64'(36'h987654321));
    chk("pre_a_hold", 64'(a_dout1), 64'(36'h123456789));

    // Lane-by-lane writes to one word.
    cycle(1'b1, 1'b1, 3'b111, 7'h07, 36'h111111111, 1'b0, 3'b000, '0, '0);
    cycle(1'b1, 1'b1, 3'b100, 7'h07, 36'h222dddccc, 1'b0, 3'b000, '0, '0);
    chk("lane_prior", 64'(a_dout1), 64'(36'h111111111));
    cycle(1'b1, 1'b1, 3'b010, 7'h07, 36'heee333ccc, 1'b0, 3'b000, '0, '0);
    cycle(1'b1, 1'b1, 3'b001, 7'h07, 36'heeeddd444, 1'b0, 3'b000, '0, '0);
    idle(3);
    chk("lane_final1", 64'(dut1.mem[7]), 64'(36'h222333444));
    chk("lane_final3", 64'(dut3.mem[7]), 64'(36'h222333444));

    // Both ports write one word at the same edge.
    cycle(1'b1, 1'b1, 3'b110, 7'h09, 36'haaaaaaaaa, 1'b1, 3'b011, 7'h09, 36'hbbbbbbbbb);
    chk("coll_a_old", 64'(a_dout1), 64'(old9));
    chk("coll_b_old", 64'(b_dout1), 64'(old9));
    idle(3);
    chk("coll_mem", 64'(dut1.mem[9]), 64'(36'haaaaaabbb));

    // Address range edges.
    cycle(1'b1, 1'b1, 3'b111, 7'd100, 36'h555555555, 1'b0, 3'b000, '0, '0);
    chk("oor_err", 64'(a_err1), 64'd1);
    chk("oor_dout", 64'(a_dout1), 64'd0);
    cycle(1'b1, 1'b1, 3'b111, 7'd99, 36'h666666666, 1'b0, 3'b000, '0, '0);
    chk("top_err", 64'(a_err1), 64'd0);
    idle(3);
    chk("top_mem", 64'(dut1.mem[99]), 64'(36'h666666666));

    // Latency-3 streaming, then reset mid-stream.
    pulses3 = 0;
    for (int i = 0; i < 4; i++) rd_a(7'h13);
    idle(4);
    chk("stream_cnt", 64'(pulses3), 64'd4);
    pulses3 = 0;
    rd_a(7'h13);
    rd_a(7'h13);
    cycle(1'b0, 1'b1, 3'b000, 7'h13, '0, 1'b0, 3'b000, '0, '0);
    idle(5);
    chk("flush_cnt", 64'(pulses3), 64'd0);
    chk("flush_mem", 64'(dut3.mem[7'h13]), 64'(36'h123456789));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63, 0) != 0),
            1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), rand_addr(), 36'({$urandom(), $urandom()}),
            1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), rand_addr(), 36'({$urandom(), $urandom()}));
    end
    idle(4);
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("mem1[%0d]", i), 64'(dut1.mem[i]), 64'(ref_mem[i]));
      chk($sformatf("mem3[%0d]", i), 64'(dut3.mem[i]), 64'(ref_mem[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
